// File: rtl/sram_fifo_mc_ctrl.sv
// NCH independent byte-granular FIFOs mapped onto one dual-port SRAM.
// Port A is write-only and port B is read-only. Each channel owns a fixed word region.
module sram_fifo_mc_ctrl #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 64,
  parameter  int NCH      = 4,
  parameter  int MAX_SIZE = 2,
  localparam int RW       = DEPTH / NCH,
  localparam int RB       = RW * WIDTH / 8,
  localparam int CW       = $clog2(NCH),
  localparam int BW       = $clog2(RB),
  localparam int CWP      = (CW > 0) ? CW : 1,
  localparam int EW       = 8 * (2 ** MAX_SIZE),
  localparam int AW       = $clog2(DEPTH),
  localparam int NB       = WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*NCH-1:0]     cfg_size,
  input  logic [NCH-1:0]       flush,
  input  logic                 wr_valid,
  input  logic [CWP-1:0]       wr_ch,
  input  logic [EW-1:0]        wr_data,
  output logic                 wr_ready,
  input  logic                 rd_req,
  input  logic [CWP-1:0]       rd_ch,
  output logic                 rd_ready,
  output logic                 rd_valid,
  output logic [EW-1:0]        rd_data,
  output logic [NCH-1:0]       empty,
  output logic [NCH-1:0]       full,
  output logic [NCH*(BW+1)-1:0] count,
  output logic [NCH-1:0]       err,
  output logic                 ce_a,
  output logic                 we_a,
  output logic [AW-1:0]        addr_a,
  output logic [NB-1:0]        wmask_a,
  output logic [WIDTH-1:0]     wdata_a,
  output logic                 ce_b,
  output logic [AW-1:0]        addr_b,
  input  logic [WIDTH-1:0]     rdata_b
);

  localparam int OW  = $clog2(NB);
  localparam int OWP = (OW > 0) ? OW : 1;

  // Handshake: a request is accepted in the cycle where valid/req and ready are
  // both high; ready depends only on registered state and flush, never on valid.

  logic [BW-1:0]  wptr_q  [NCH];
  logic [BW-1:0]  wptr_d  [NCH];
  logic [BW-1:0]  rptr_q  [NCH];
  logic [BW-1:0]  rptr_d  [NCH];
  logic [BW:0]    count_q [NCH];
  logic [BW:0]    count_d [NCH];
  logic [1:0]     size_q  [NCH];
  logic [1:0]     size_d  [NCH];
  logic [NCH-1:0] err_q, err_d;
  logic [BW:0]    nbytes  [NCH];
  logic [NCH-1:0] full_c, empty_c;
  logic [NCH-1:0] w_hit, r_hit, w_rej, r_rej;

  logic           rd_valid_q, rd_valid_d;
  logic [OWP-1:0] rd_off_q, rd_off_d;
  logic [1:0]     rd_size_q, rd_size_d;

  logic           wr_acc, rd_acc;
  logic [BW-1:0]  wp, rp;
  logic [OWP-1:0] woff, roff;
  logic [NB-1:0]  wbase;
  logic [WIDTH-1:0] rshift, rmask;
  logic [7:0]     rbits;

  function automatic logic [1:0] clamp_size(input logic [1:0] s);
    if (int'(s) > MAX_SIZE) return 2'(MAX_SIZE);
    return s;
  endfunction

  function automatic logic [AW-1:0] chan_addr(input logic [CWP-1:0] ch, input logic [BW-1:0] p);
    return AW'(AW'(ch) * AW'(RW)) + AW'(p >> OW);
  endfunction

  always_comb begin
    count = '0;
    for (int c = 0; c < NCH; c++) begin
      nbytes[c]  = (BW+1)'(1) << size_q[c];
      empty_c[c] = (count_q[c] == '0);
      full_c[c]  = (((BW+1)'(RB) - count_q[c]) < nbytes[c]);
      count[c*(BW+1) +: BW+1] = count_q[c];
    end
  end

  assign empty    = empty_c;
  assign full     = full_c;
  assign err      = err_q;
  assign rd_valid = rd_valid_q;

  always_comb begin
    wr_ready = !rst && !full_c[wr_ch] && !flush[wr_ch];
    rd_ready = !rst && !empty_c[rd_ch] && !flush[rd_ch];
    wr_acc   = wr_valid && wr_ready;
    rd_acc   = rd_req && rd_ready;

    wp    = wptr_q[wr_ch];
    rp    = rptr_q[rd_ch];
    woff  = OWP'(wp) & OWP'(NB - 1);
    roff  = OWP'(rp) & OWP'(NB - 1);
    wbase = ~({NB{1'b1}} << nbytes[wr_ch]);

    ce_a    = wr_acc;
    we_a    = wr_acc;
    addr_a  = chan_addr(wr_ch, wp);
    wmask_a = wr_acc ? (wbase << woff) : '0;
    wdata_a = wr_acc ? (WIDTH'(wr_data) << {woff, 3'b000}) : '0;

    ce_b   = rd_acc;
    addr_b = chan_addr(rd_ch, rp);

    rd_valid_d = rd_acc;
    rd_off_d   = roff;
    rd_size_d  = size_q[rd_ch];

    // Response uses the offset/size captured at accept, so a flush in between is harmless.
    rbits   = 8'd8 << rd_size_q;
    rshift  = rdata_b >> {rd_off_q, 3'b000};
    rmask   = ~({WIDTH{1'b1}} << rbits);
    rd_data = rd_valid_q ? EW'(rshift & rmask) : '0;
  end

  always_comb begin
    err_d = err_q;
    for (int c = 0; c < NCH; c++) begin
      wptr_d[c]  = wptr_q[c];
      rptr_d[c]  = rptr_q[c];
      count_d[c] = count_q[c];
      size_d[c]  = size_q[c];
      w_hit[c]   = wr_acc && (wr_ch == CWP'(c));
      r_hit[c]   = rd_acc && (rd_ch == CWP'(c));
      w_rej[c]   = wr_valid && !wr_ready && (wr_ch == CWP'(c));
      r_rej[c]   = rd_req && !rd_ready && (rd_ch == CWP'(c));
      if (flush[c]) begin
        wptr_d[c]  = '0;
        rptr_d[c]  = '0;
        count_d[c] = '0;
        size_d[c]  = clamp_size(cfg_size[2*c +: 2]);
        err_d[c]   = 1'b0;
      end else begin
        if (w_hit[c]) wptr_d[c] = wptr_q[c] + nbytes[c][BW-1:0];
        if (r_hit[c]) rptr_d[c] = rptr_q[c] + nbytes[c][BW-1:0];
        count_d[c] = count_q[c] + (w_hit[c] ? nbytes[c] : '0) - (r_hit[c] ? nbytes[c] : '0);
        if (w_rej[c] || r_rej[c]) err_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        count_q[c] <= '0;
        size_q[c]  <= clamp_size(cfg_size[2*c +: 2]);
      end
      err_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_off_q   <= '0;
      rd_size_q  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c]  <= wptr_d[c];
        rptr_q[c]  <= rptr_d[c];
        count_q[c] <= count_d[c];
        size_q[c]  <= size_d[c];
      end
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_off_q   <= rd_off_d;
      rd_size_q  <= rd_size_d;
    end
  end

endmodule

// File: tb/tb_sram_fifo_mc_ctrl.sv
// Bench for sram_fifo_mc_ctrl: SRAM model, reference FIFO model per channel,
// read-data scoreboard, a vector table for byte mode and directed corner sequences.
module tb_sram_fifo_mc_ctrl;
  localparam int DEPTH = 64, NCH = 4, MAX_SIZE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_size;
  logic [3:0]  flush;
  logic        wr_valid, wr_ready, rd_req, rd_ready, rd_valid;
  logic [1:0]  wr_ch, rd_ch;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  empty, full, err;
  logic [27:0] count;
  logic        ce_a, we_a, ce_b;
  logic [5:0]  addr_a, addr_b;
  logic [3:0]  wmask_a;
  logic [31:0] wdata_a, rdata_b;

  logic [31:0] mem [DEPTH];

  int n_tests, n_fail;
  logic [31:0] exp_q [$];
  logic [31:0] mdl [NCH][$];
  int   mwp [NCH], mrp [NCH], mcnt [NCH], msz [NCH];
  logic merr [NCH];
  logic [5:0] cap_addr_a, cap_addr_b;
  logic [3:0] cap_wmask_a;
  logic       cap_rd_valid;

  typedef struct {
    logic       is_wr;
    int         ch;
    logic [31:0] data;
    logic [5:0] exp_addr;
    logic [3:0] exp_mask;
  } vec_t;
  vec_t vecs [8];

  sram_fifo_mc_ctrl dut (
    .clk(clk), .rst(rst), .cfg_size(cfg_size), .flush(flush),
    .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count), .err(err),
    .ce_a(ce_a), .we_a(we_a), .addr_a(addr_a), .wmask_a(wmask_a), .wdata_a(wdata_a),
    .ce_b(ce_b), .addr_b(addr_b), .rdata_b(rdata_b)
  );

  // clock / reset and SRAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce_a && we_a)
      for (int b = 0; b < 4; b++)
        if (wmask_a[b]) mem[addr_a][8*b +: 8] <= wdata_a[8*b +: 8];
    if (ce_b) rdata_b <= mem[addr_b];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int clampi(input int s);
    return (s > MAX_SIZE) ? MAX_SIZE : s;
  endfunction

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  // scoreboard: every rd_valid pops one expected element
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_valid_spurious: got rd_valid=1 with rd_data=0x%0h, expected no response", rd_data);
        end else begin
          chk("rd_data", {32'd0, rd_data}, {32'd0, exp_q.pop_front()});
        end
      end else begin
        chk("rd_data_idle", {32'd0, rd_data}, 64'd0);
      end
    end
  end

  // driver: one clock cycle of stimulus, checked against the reference model
  task automatic cycle(input logic wv, input int wc, input logic [31:0] wd,
                       input logic rq, input int rc, input logic [3:0] fl);
    logic wexp, rexp;
    int wn, rn, woff;
    logic [3:0] em;
    logic [31:0] wmasked;
    wr_valid = wv; wr_ch = 2'(wc); wr_data = wd;
    rd_req = rq; rd_ch = 2'(rc); flush = fl;
    wn   = 1 << msz[wc];
    rn   = 1 << msz[rc];
    woff = mwp[wc] % 4;
    wexp = wv && ((64 - mcnt[wc]) >= wn) && !fl[wc];
    rexp = rq && (mcnt[rc] != 0) && !fl[rc];
    em   = 4'(((1 << wn) - 1) << woff);
    wmasked = wd & ((32'd1 << (8 * wn)) - 32'd1);
    @(negedge clk);
    if (wv) chk("wr_ready", {63'd0, wr_ready}, {63'd0, wexp});
    if (rq) chk("rd_ready", {63'd0, rd_ready}, {63'd0, rexp});
    chk("ce_a", {63'd0, ce_a}, {63'd0, wexp});
    chk("ce_b", {63'd0, ce_b}, {63'd0, rexp});
    cap_addr_a = addr_a; cap_wmask_a = wmask_a; cap_addr_b = addr_b; cap_rd_valid = rd_valid;
    if (wexp) begin
      chk("we_a", {63'd0, we_a}, 64'd1);
      chk("addr_a", {58'd0, addr_a}, 64'(wc * 16 + mwp[wc] / 4));
      chk("wmask_a", {60'd0, wmask_a}, {60'd0, em});
      chk("wdata_a", {32'd0, wdata_a & expand(em)}, {32'd0, wmasked << (8 * woff)});
    end
    if (rexp) begin
      chk("addr_b", {58'd0, addr_b}, 64'(rc * 16 + mrp[rc] / 4));
      if (mdl[rc].size() > 0) exp_q.push_back(mdl[rc].pop_front());
    end
    if (wv && !fl[wc] && !wexp) merr[wc] = 1'b1;
    if (rq && !fl[rc] && !rexp) merr[rc] = 1'b1;
    @(posedge clk);
    #1;
    if (wexp) begin
      mdl[wc].push_back(wmasked);
      mwp[wc]  = (mwp[wc] + wn) % 64;
      mcnt[wc] = mcnt[wc] + wn;
    end
    if (rexp) begin
      mrp[rc]  = (mrp[rc] + rn) % 64;
      mcnt[rc] = mcnt[rc] - rn;
    end
    for (int c = 0; c < NCH; c++) begin
      if (fl[c]) begin
        mwp[c] = 0; mrp[c] = 0; mcnt[c] = 0; merr[c] = 1'b0;
        msz[c] = clampi(int'(cfg_size[2*c +: 2]));
        mdl[c].delete();
      end
    end
    wr_valid = 1'b0; rd_req = 1'b0; flush = 4'b0000;
  endtask

  task automatic chk_status(input int c);
    chk("count", {57'd0, count[c*7 +: 7]}, 64'(mcnt[c]));
    chk("empty", {63'd0, empty[c]}, {63'd0, mcnt[c] == 0});
    chk("full", {63'd0, full[c]}, {63'd0, (64 - mcnt[c]) < (1 << msz[c])});
    chk("err", {63'd0, err[c]}, {63'd0, merr[c]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_a;
    logic saw_wrap;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; cfg_size = 8'h00; flush = 4'b0000;
    wr_valid = 1'b0; wr_ch = 2'd0; wr_data = 32'd0;
    rd_req = 1'b0; rd_ch = 2'd0;
    for (int c = 0; c < NCH; c++) begin
      mwp[c] = 0; mrp[c] = 0; mcnt[c] = 0; msz[c] = 0; merr[c] = 1'b0;
    end
    vecs[0] = '{1'b1, 1, 32'hA1, 6'd16, 4'b0001};
    vecs[1] = '{1'b1, 1, 32'hB2, 6'd16, 4'b0010};
    vecs[2] = '{1'b1, 1, 32'hC3, 6'd16, 4'b0100};
    vecs[3] = '{1'b1, 1, 32'hD4, 6'd16, 4'b1000};
    vecs[4] = '{1'b0, 1, 32'h0,  6'd16, 4'b0000};
    vecs[5] = '{1'b0, 1, 32'h0,  6'd16, 4'b0000};
    vecs[6] = '{1'b0, 1, 32'h0,  6'd16, 4'b0000};
    vecs[7] = '{1'b0, 1, 32'h0,  6'd16, 4'b0000};

    // reset: requests during reset must not touch the SRAM
    repeat (2) @(posedge clk);
    #1;
    wr_valid = 1'b1; rd_req = 1'b1;
    @(negedge clk);
    chk("rst_ce_a", {63'd0, ce_a}, 64'd0);
    chk("rst_ce_b", {63'd0, ce_b}, 64'd0);
    chk("rst_wmask", {60'd0, wmask_a}, 64'd0);
    @(posedge clk);
    #1;
    wr_valid = 1'b0; rd_req = 1'b0; rst = 1'b0;
    chk("rst_empty", {60'd0, empty}, 64'hF);
    chk("rst_full", {60'd0, full}, 64'd0);
    chk("rst_count", {36'd0, count}, 64'd0);
    chk("rst_err", {60'd0, err}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);

    // size clamp: cfg 3 on channel 3 behaves as word mode
    cfg_size = {2'd3, 2'd1, 2'd0, 2'd2};
    cycle(1'b0, 0, 32'd0, 1'b0, 0, 4'b1111);
    cycle(1'b1, 3, 32'h11223344, 1'b0, 0, 4'b0000);
    chk("clamp_mask", {60'd0, cap_wmask_a}, 64'hF);
    cycle(1'b0, 0, 32'd0, 1'b1, 3, 4'b0000);
    cfg_size = {2'd0, 2'd1, 2'd0, 2'd2};
    cycle(1'b0, 0, 32'd0, 1'b0, 0, 4'b1000);

    // byte mode vector table on channel 1
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) begin
        cycle(1'b1, vecs[i].ch, vecs[i].data, 1'b0, 0, 4'b0000);
        chk("t2_addr_a", {58'd0, cap_addr_a}, {58'd0, vecs[i].exp_addr});
        chk("t2_wmask", {60'd0, cap_wmask_a}, {60'd0, vecs[i].exp_mask});
      end else begin
        cycle(1'b0, 0, 32'd0, 1'b1, vecs[i].ch, 4'b0000);
        chk("t2_addr_b", {58'd0, cap_addr_b}, {58'd0, vecs[i].exp_addr});
      end
      if (i == 3) chk("t2_count1", {57'd0, count[13:7]}, 64'd4);
    end
    cycle(1'b0, 0, 32'd0, 1'b0, 0, 4'b0000);
    chk("t2_empty1", {63'd0, empty[1]}, 64'd1);

    // underflow sets err, flush clears it
    cycle(1'b0, 0, 32'd0, 1'b1, 1, 4'b0000);
    chk("uflow_err1", {63'd0, err[1]}, 64'd1);
    cycle(1'b0, 0, 32'd0, 1'b0, 0, 4'b0010);
    chk("flush_err1", {63'd0, err[1]}, 64'd0);

    // word mode fill of channel 0, then overflow
    for (int i = 0; i < 16; i++) cycle(1'b1, 0, $urandom(), 1'b0, 0, 4'b0000);
    chk("t3_full0", {63'd0, full[0]}, 64'd1);
    chk("t3_count0", {57'd0, count[6:0]}, 64'd64);
    cycle(1'b1, 0, $urandom(), 1'b0, 0, 4'b0000);
    chk("t3_err0", {63'd0, err[0]}, 64'd1);
    chk("t3_count0_hold", {57'd0, count[6:0]}, 64'd64);
    cycle(1'b0, 0, 32'd0, 1'b0, 0, 4'b0000);
    chk("t3_err0_sticky", {63'd0, err[0]}, 64'd1);

    // halfword streaming on channel 2 with address wrap
    prev_a = 0; saw_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 2, $urandom_range(32'h0000FFFF, 0), i >= 16, 2, 4'b0000);
      if (prev_a == 47 && cap_addr_a == 6'd32) saw_wrap = 1'b1;
      prev_a = int'(cap_addr_a);
    end
    chk("t4_wrap", {63'd0, saw_wrap}, 64'd1);
    chk("t4_count2", {57'd0, count[20:14]}, 64'd32);
    chk_status(2);

    // simultaneous read and write: mid-fill and at full
    for (int i = 0; i < 8; i++) cycle(1'b1, 3, $urandom_range(255, 0), 1'b0, 0, 4'b0000);
    cycle(1'b1, 3, $urandom_range(255, 0), 1'b1, 3, 4'b0000);
    chk("t5_count3", {57'd0, count[27:21]}, 64'd8);
    cycle(1'b1, 0, $urandom(), 1'b1, 0, 4'b0000);
    chk("t5_count0", {57'd0, count[6:0]}, 64'd60);
    chk_status(0);

    // read in flight across a flush that also changes element size
    cycle(1'b0, 0, 32'd0, 1'b1, 3, 4'b0000);
    cfg_size[7:6] = 2'd1;
    cycle(1'b1, 3, 32'h0000DEAD, 1'b0, 0, 4'b1000);
    chk("t6_rd_valid", {63'd0, cap_rd_valid}, 64'd1);
    chk("t6_err3", {63'd0, err[3]}, 64'd0);
    chk("t6_count3", {57'd0, count[27:21]}, 64'd0);
    cycle(1'b1, 3, 32'h0000BEEF, 1'b0, 0, 4'b0000);
    chk("t6_mask_lo", {60'd0, cap_wmask_a}, 64'h3);
    cycle(1'b1, 3, 32'h0000CAFE, 1'b0, 0, 4'b0000);
    chk("t6_mask_hi", {60'd0, cap_wmask_a}, 64'hC);
    cycle(1'b0, 0, 32'd0, 1'b1, 3, 4'b0000);
    cycle(1'b0, 0, 32'd0, 1'b1, 3, 4'b0000);
    repeat (2) cycle(1'b0, 0, 32'd0, 1'b0, 0, 4'b0000);

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    for (int c = 0; c < NCH; c++) chk_status(c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
